// File: rtl/hwpe_job_dispatcher.sv
// Shares one HWPE among N_CORES cores: round-robin job intake into an in-order FIFO,
// one job in flight at a time, completion event routed back to the submitting core.
module hwpe_job_dispatcher #(
    parameter int unsigned N_CORES        = 8,
    parameter int unsigned JOB_FIFO_DEPTH = 4,
    parameter int unsigned CORE_ID_W      = $clog2(N_CORES)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                clear_i,
    input  logic [N_CORES-1:0]                  job_req_i,
    output logic [N_CORES-1:0]                  job_gnt_o,
    output logic                                hwpe_trigger_o,
    output logic [CORE_ID_W-1:0]                hwpe_job_id_o,
    input  logic                                hwpe_done_i,
    output logic [N_CORES-1:0]                  evt_o,
    output logic                                busy_o,
    output logic [$clog2(JOB_FIFO_DEPTH+1)-1:0] pending_cnt_o
);
    localparam int unsigned PTR_W = $clog2(JOB_FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(JOB_FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, TRIGGER, RUN, EVT} state_t;

    state_t               state;
    logic [CORE_ID_W-1:0] mem [JOB_FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [CORE_ID_W-1:0] rr_ptr, winner, cand;
    logic                 found, full, push, pop;
    int unsigned          idx;

    // Full is registered occupancy only, so a same-cycle pop never admits a push.
    assign full = (count == CNT_W'(JOB_FIFO_DEPTH));
    assign push = found;
    assign pop  = (state == IDLE) && (count != '0) && !clear_i;

    assign pending_cnt_o = count;
    assign busy_o        = (state != IDLE) || (count != '0);

    always_comb begin
        job_gnt_o = '0;
        winner    = '0;
        cand      = '0;
        found     = 1'b0;
        idx       = 0;
        if (!full && !clear_i) begin
            for (int unsigned i = 0; i < N_CORES; i++) begin
                idx = 32'(rr_ptr) + i;
                if (idx >= N_CORES) idx = idx - N_CORES;
                cand = CORE_ID_W'(idx);
                if (!found && job_req_i[cand]) begin
                    found  = 1'b1;
                    winner = cand;
                end
            end
        end
        if (found) job_gnt_o[winner] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= winner;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rr_ptr <= '0;
        end else if (clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                rr_ptr <= (winner == CORE_ID_W'(N_CORES - 1)) ? '0 : winner + CORE_ID_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (!push && pop) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            hwpe_job_id_o  <= '0;
            hwpe_trigger_o <= 1'b0;
            evt_o          <= '0;
        end else begin
            hwpe_trigger_o <= 1'b0;
            evt_o          <= '0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        hwpe_job_id_o  <= mem[rd_ptr];
                        hwpe_trigger_o <= 1'b1;
                        state          <= TRIGGER;
                    end
                end
                TRIGGER: state <= RUN;
                RUN: begin
                    if (hwpe_done_i) begin
                        evt_o <= N_CORES'(1) << hwpe_job_id_o;
                        state <= EVT;
                    end
                end
                EVT:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hwpe_job_dispatcher.sv
// Directed-vector bench for hwpe_job_dispatcher; expected values hand-derived per cycle.
module tb_hwpe_job_dispatcher;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear_i = 1'b0;
    logic [7:0] job_req_i = '0;
    logic [7:0] job_gnt_o;
    logic       hwpe_trigger_o;
    logic [2:0] hwpe_job_id_o;
    logic       hwpe_done_i = 1'b0;
    logic [7:0] evt_o;
    logic       busy_o;
    logic [2:0] pending_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    hwpe_job_dispatcher #(.N_CORES(8), .JOB_FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .clear_i(clear_i), .job_req_i(job_req_i),
        .job_gnt_o(job_gnt_o), .hwpe_trigger_o(hwpe_trigger_o),
        .hwpe_job_id_o(hwpe_job_id_o), .hwpe_done_i(hwpe_done_i), .evt_o(evt_o),
        .busy_o(busy_o), .pending_cnt_o(pending_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; job_req_i = '0; hwpe_done_i = 1'b0; clear_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if ({job_gnt_o, evt_o} !== 16'h0) begin n_err++; $display("FAIL reset gnt/evt got %h want 0000", {job_gnt_o, evt_o}); end
        n_cmp++; if ({hwpe_trigger_o, busy_o} !== 2'b00) begin n_err++; $display("FAIL reset trig/busy got %b want 00", {hwpe_trigger_o, busy_o}); end
        n_cmp++; if ({hwpe_job_id_o, pending_cnt_o} !== 6'h0) begin n_err++; $display("FAIL reset id/cnt got %h want 00", {hwpe_job_id_o, pending_cnt_o}); end
        do_reset();
    endtask

    task automatic test_single();
        logic [7:0] ge, ee;
        do_reset();
        for (int t = 0; t < 14; t++) begin
            tick();
            job_req_i   = (t == 0) ? 8'h08 : 8'h00;
            hwpe_done_i = (t == 10);
            #1;
            ge = (t == 0) ? 8'h08 : 8'h00;
            ee = (t == 11) ? 8'h08 : 8'h00;
            n_cmp++; if (job_gnt_o !== ge) begin n_err++; $display("FAIL single gnt t=%0d got %h want %h", t, job_gnt_o, ge); end
            n_cmp++; if (hwpe_trigger_o !== (t == 2)) begin n_err++; $display("FAIL single trig t=%0d got %b want %b", t, hwpe_trigger_o, t == 2); end
            n_cmp++; if (evt_o !== ee) begin n_err++; $display("FAIL single evt t=%0d got %h want %h", t, evt_o, ee); end
            n_cmp++; if (busy_o !== (t >= 1 && t <= 11)) begin n_err++; $display("FAIL single busy t=%0d got %b", t, busy_o); end
            if (t == 2) begin
                n_cmp++; if (hwpe_job_id_o !== 3'd3) begin n_err++; $display("FAIL single id got %0d want 3", hwpe_job_id_o); end
            end
        end
        hwpe_done_i = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [7:0] ge, ee;
        logic [2:0] ide;
        do_reset();
        for (int t = 0; t < 19; t++) begin
            tick();
            case (t)
                0: job_req_i = 8'h25;  1: job_req_i = 8'h24;
                2: job_req_i = 8'h20;  18: job_req_i = 8'h61;
                default: job_req_i = 8'h00;
            endcase
            hwpe_done_i = (t == 5 || t == 10 || t == 15);
            #1;
            case (t)
                0: ge = 8'h01;  1: ge = 8'h04;  2: ge = 8'h20;  18: ge = 8'h40;
                default: ge = 8'h00;
            endcase
            case (t)
                6: ee = 8'h01;  11: ee = 8'h04;  16: ee = 8'h20;
                default: ee = 8'h00;
            endcase
            n_cmp++; if (job_gnt_o !== ge) begin n_err++; $display("FAIL rr gnt t=%0d got %h want %h", t, job_gnt_o, ge); end
            n_cmp++; if (hwpe_trigger_o !== (t == 2 || t == 8 || t == 13)) begin n_err++; $display("FAIL rr trig t=%0d got %b", t, hwpe_trigger_o); end
            n_cmp++; if (evt_o !== ee) begin n_err++; $display("FAIL rr evt t=%0d got %h want %h", t, evt_o, ee); end
            n_cmp++; if (busy_o !== (t >= 1 && t <= 16)) begin n_err++; $display("FAIL rr busy t=%0d got %b", t, busy_o); end
            if (t == 2 || t == 8 || t == 13) begin
                ide = (t == 2) ? 3'd0 : (t == 8) ? 3'd2 : 3'd5;
                n_cmp++; if (hwpe_job_id_o !== ide) begin n_err++; $display("FAIL rr id t=%0d got %0d want %0d", t, hwpe_job_id_o, ide); end
            end
        end
        job_req_i = '0; hwpe_done_i = 1'b0;
    endtask

    task automatic test_fifo_full();
        logic [7:0] ge;
        do_reset();
        for (int t = 0; t < 13; t++) begin
            tick();
            case (t)
                0: job_req_i = 8'h80;  1, 2: job_req_i = 8'h00;
                3: job_req_i = 8'h7F;  4: job_req_i = 8'h7E;
                5: job_req_i = 8'h7C;  6: job_req_i = 8'h78;
                7, 8, 9, 10, 11: job_req_i = 8'h70;
                default: job_req_i = 8'h60;
            endcase
            hwpe_done_i = (t == 8);
            #1;
            case (t)
                0: ge = 8'h80;  3: ge = 8'h01;  4: ge = 8'h02;
                5: ge = 8'h04;  6: ge = 8'h08;  11: ge = 8'h10;
                default: ge = 8'h00;
            endcase
            n_cmp++; if (job_gnt_o !== ge) begin n_err++; $display("FAIL full gnt t=%0d got %h want %h", t, job_gnt_o, ge); end
            n_cmp++; if (evt_o !== ((t == 9) ? 8'h80 : 8'h00)) begin n_err++; $display("FAIL full evt t=%0d got %h", t, evt_o); end
            if (t == 7 || t == 10 || t == 11 || t == 12) begin
                n_cmp++;
                if (pending_cnt_o !== ((t == 11) ? 3'd3 : 3'd4)) begin
                    n_err++; $display("FAIL full cnt t=%0d got %0d want %0d", t, pending_cnt_o, (t == 11) ? 3 : 4);
                end
            end
            if (t == 11) begin
                n_cmp++; if (hwpe_trigger_o !== 1'b1 || hwpe_job_id_o !== 3'd0) begin n_err++; $display("FAIL full trig got %b id %0d want 1 id 0", hwpe_trigger_o, hwpe_job_id_o); end
            end
        end
        job_req_i = '0; hwpe_done_i = 1'b0;
    endtask

    task automatic test_spurious_done();
        do_reset();
        for (int t = 0; t < 11; t++) begin
            tick();
            job_req_i   = (t == 1) ? 8'h02 : 8'h00;
            hwpe_done_i = (t == 0 || t == 3 || t == 7);
            #1;
            n_cmp++; if (evt_o !== ((t == 8) ? 8'h02 : 8'h00)) begin n_err++; $display("FAIL spur evt t=%0d got %h", t, evt_o); end
            n_cmp++; if (hwpe_trigger_o !== (t == 3)) begin n_err++; $display("FAIL spur trig t=%0d got %b", t, hwpe_trigger_o); end
            n_cmp++; if (busy_o !== (t >= 2 && t <= 8)) begin n_err++; $display("FAIL spur busy t=%0d got %b", t, busy_o); end
        end
        hwpe_done_i = 1'b0;
    endtask

    task automatic test_clear();
        logic [7:0] ge;
        do_reset();
        for (int t = 0; t < 13; t++) begin
            tick();
            case (t)
                0: job_req_i = 8'h07;  1: job_req_i = 8'h06;
                2: job_req_i = 8'h04;  4: job_req_i = 8'h08;
                default: job_req_i = 8'h00;
            endcase
            clear_i     = (t == 4);
            hwpe_done_i = (t == 7);
            #1;
            case (t)
                0: ge = 8'h01;  1: ge = 8'h02;  2: ge = 8'h04;
                default: ge = 8'h00;
            endcase
            n_cmp++; if (job_gnt_o !== ge) begin n_err++; $display("FAIL clear gnt t=%0d got %h want %h", t, job_gnt_o, ge); end
            n_cmp++; if (hwpe_trigger_o !== (t == 2)) begin n_err++; $display("FAIL clear trig t=%0d got %b", t, hwpe_trigger_o); end
            n_cmp++; if (evt_o !== ((t == 8) ? 8'h01 : 8'h00)) begin n_err++; $display("FAIL clear evt t=%0d got %h", t, evt_o); end
            n_cmp++; if (busy_o !== (t >= 1 && t <= 8)) begin n_err++; $display("FAIL clear busy t=%0d got %b", t, busy_o); end
            if (t >= 3 && t <= 5) begin
                n_cmp++;
                if (pending_cnt_o !== ((t == 5) ? 3'd0 : 3'd2)) begin
                    n_err++; $display("FAIL clear cnt t=%0d got %0d want %0d", t, pending_cnt_o, (t == 5) ? 0 : 2);
                end
            end
        end
        clear_i = 1'b0; hwpe_done_i = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int t = 0; t < 4; t++) begin
            tick();
            case (t)
                0: job_req_i = 8'h0E;  1: job_req_i = 8'h0C;
                2: job_req_i = 8'h08;  default: job_req_i = 8'h00;
            endcase
            #1;
        end
        n_cmp++; if (pending_cnt_o !== 3'd2 || hwpe_job_id_o !== 3'd1) begin n_err++; $display("FAIL areset pre cnt %0d id %0d want 2 1", pending_cnt_o, hwpe_job_id_o); end
        tick();
        rst = 1'b1;
        #1;
        n_cmp++; if ({busy_o, hwpe_trigger_o} !== 2'b00) begin n_err++; $display("FAIL areset busy/trig got %b want 00", {busy_o, hwpe_trigger_o}); end
        n_cmp++; if (pending_cnt_o !== 3'd0) begin n_err++; $display("FAIL areset cnt got %0d want 0", pending_cnt_o); end
        n_cmp++; if ({hwpe_job_id_o, evt_o, job_gnt_o} !== 19'h0) begin n_err++; $display("FAIL areset id/evt/gnt got %h want 0", {hwpe_job_id_o, evt_o, job_gnt_o}); end
        #1 rst = 1'b0;
        for (int t = 0; t < 4; t++) begin
            tick();
            job_req_i = (t == 0) ? 8'h20 : 8'h00;
            #1;
            n_cmp++; if (job_gnt_o !== ((t == 0) ? 8'h20 : 8'h00)) begin n_err++; $display("FAIL areset post gnt t=%0d got %h", t, job_gnt_o); end
            n_cmp++; if (hwpe_trigger_o !== (t == 2)) begin n_err++; $display("FAIL areset post trig t=%0d got %b", t, hwpe_trigger_o); end
            if (t == 2) begin
                n_cmp++; if (hwpe_job_id_o !== 3'd5) begin n_err++; $display("FAIL areset post id got %0d want 5", hwpe_job_id_o); end
            end
        end
        job_req_i = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fifo_full();
        test_spurious_done();
        test_clear();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
